// File: rtl/gray_threshold_binarizer_pkg.sv
// Shared definitions for the grayscale binarizer and the binary-to-RGB stage:
// frame geometry, binary pixel codes and the stream FSM state type.
package gray_threshold_binarizer_pkg;

    typedef logic [7:0] pixel_t;

    localparam int unsigned FRAME_W      = 10;
    localparam int unsigned FRAME_H      = 10;
    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;

    localparam pixel_t BIN_ONE  = 8'hFF;
    localparam pixel_t BIN_ZERO = 8'h00;

    typedef enum logic {
        STREAM = 1'b0,
        DIVIDE = 1'b1
    } bin_state_t;

    // Clamp a wide unsigned value into an 8-bit pixel.
    function automatic pixel_t sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/gray_threshold_binarizer_if.sv
// Pixel stream bundle: grayscale input handshake plus binary output
// handshake with frame markers. The block takes the slave view.
interface gray_threshold_binarizer_if;
    import gray_threshold_binarizer_pkg::*;

    pixel_t in_pixel;
    logic   in_valid;
    logic   in_ready;
    pixel_t out_pixel;
    logic   out_valid;
    logic   out_ready;
    logic   out_sof;
    logic   out_eof;

    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_pixel, out_valid, out_sof, out_eof
    );

    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_pixel, out_valid, out_sof, out_eof
    );

endinterface

// File: rtl/gray_threshold_binarizer_seq_divider.sv
// Restoring divider, one quotient bit per cycle, DIVIDEND_W cycles per run.
// done and quotient are valid together during the final step so the caller
// can capture the result on the same edge the divider goes idle.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 15,
    parameter int unsigned DIVISOR_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);
    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  run_q;

    logic [DIVISOR_W:0]    partial;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic [DIVISOR_W-1:0]  rem_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        partial  = {rem_q, quot_q[DIVIDEND_W-1]};
        trial    = partial - {1'b0, dsr_q};
        fits     = (partial >= {1'b0, dsr_q});
        rem_next = DIVISOR_W'(fits ? trial : partial);
    end

    assign quotient = {quot_q[DIVIDEND_W-2:0], fits};
    assign done     = run_q && (cnt_q == CNT_W'(1));

    // Load operands on start, then iterate until the bit counter expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else if (start && !run_q) begin
            quot_q <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            cnt_q  <= CNT_W'(DIVIDEND_W);
            run_q  <= 1'b1;
        end else if (run_q) begin
            quot_q <= quotient;
            rem_q  <= rem_next;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gray_threshold_binarizer.sv
// Streaming grayscale-to-binary stage. Threshold is static or the floor mean
// of the previous frame, computed by a sequential divider between frames.
module gray_threshold_binarizer
    import gray_threshold_binarizer_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_W,
    parameter int unsigned HEIGHT = FRAME_H,
    parameter int unsigned SUM_W  = $clog2(WIDTH * HEIGHT * 255 + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_mode,
    input  pixel_t                        cfg_threshold,
    gray_threshold_binarizer_if.slave     bus,
    output pixel_t                        frame_mean,
    output logic                          busy
);
    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam int unsigned DIV_W  = $clog2(PIXELS + 1);
    localparam int unsigned COL_W  = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W  = $clog2(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    bin_state_t       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [SUM_W-1:0] sum;
    pixel_t           thr;
    logic             mean_valid;
    pixel_t           mean_q;
    logic             busy_q;
    pixel_t           out_pixel_q;
    logic             out_valid_q;
    logic             out_sof_q;
    logic             out_eof_q;

    logic             accept;
    logic             first_px;
    logic             last_px;
    pixel_t           thr_frame;
    pixel_t           thr_use;
    logic [SUM_W-1:0] sum_next;
    logic             div_start;
    logic             div_done;
    logic [SUM_W-1:0] div_quot;

    assign first_px  = (col == '0) && (row == '0);
    assign last_px   = (col == COL_LAST) && (row == ROW_LAST);
    assign thr_frame = (cfg_mode && mean_valid) ? mean_q : cfg_threshold;
    // Pixel (0,0) compares against the value being latched on the same edge.
    assign thr_use   = first_px ? thr_frame : thr;
    assign sum_next  = sum + SUM_W'(bus.in_pixel);

    assign bus.in_ready = rst_n && (state == STREAM) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    // The dividend includes the final pixel, so start straight from sum_next.
    assign div_start    = accept && last_px;

    assign bus.out_pixel = out_pixel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign frame_mean    = mean_q;
    assign busy          = busy_q;

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_next),
        .divisor  (DIV_W'(PIXELS)),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Output register, raster counters, accumulator and STREAM/DIVIDE control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= STREAM;
            col         <= '0;
            row         <= '0;
            sum         <= '0;
            thr         <= '0;
            mean_valid  <= 1'b0;
            mean_q      <= '0;
            busy_q      <= 1'b0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_pixel_q <= (bus.in_pixel >= thr_use) ? BIN_ONE : BIN_ZERO;
                out_sof_q   <= first_px;
                out_eof_q   <= last_px;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                STREAM: begin
                    if (accept) begin
                        sum <= sum_next;
                        if (first_px) begin
                            thr <= thr_frame;
                        end
                        if (last_px) begin
                            col    <= '0;
                            row    <= '0;
                            state  <= DIVIDE;
                            busy_q <= 1'b1;
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        mean_q     <= sat_u8(32'(div_quot));
                        mean_valid <= 1'b1;
                        sum        <= '0;
                        state      <= STREAM;
                        busy_q     <= 1'b0;
                    end
                end
                default: state <= STREAM;
            endcase
        end
    end

endmodule

// File: doc/gray_threshold_binarizer.md
# gray_threshold_binarizer

Streaming binarization stage that converts 8-bit grayscale pixels into binary pixels (0x00 / 0xFF). It sits directly upstream of the binary-to-RGB expander and feeds it one pixel per accepted transfer in raster order. The threshold is either a static configured value or the floor mean of the previous frame, computed by an on-block sequential divider between frames.

## Interface
Parameters:
- WIDTH, 10, pixels per row
- HEIGHT, 10, rows per frame
- SUM_W, derived, $clog2(WIDTH*HEIGHT*255+1) (15 for 10x10), accumulator width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_mode  in  1  0 = static threshold, 1 = adaptive (previous-frame mean)
- cfg_threshold  in  8  static threshold; also used in adaptive mode until a mean exists
- in_pixel  in  8  grayscale pixel
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- out_pixel  out  8  binary pixel, 0x00 or 0xFF only
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  qualifies first pixel of frame
- out_eof  out  1  qualifies last pixel of frame
- frame_mean  out  8  last computed frame mean
- busy  out  1  high while divider runs

## Operation
- FSM states: STREAM, DIVIDE.
- STREAM: transfer on in_valid && in_ready; in_ready = !out_valid || out_ready.
- On accepting pixel (col,row)=(0,0): latch active threshold = (cfg_mode && mean_valid) ? frame_mean : cfg_threshold; cfg inputs ignored for rest of frame. Pixel (0,0) is itself compared against the newly latched value.
- Compare: in_pixel >= threshold -> 0xFF, else 0x00. Equality gives 0xFF.
- Each accepted pixel added to SUM_W-bit sum (never overflows by construction).
- col counts 0..WIDTH-1, wraps to 0 and increments row; row wraps after HEIGHT-1.
- Accepting the last pixel (WIDTH-1,HEIGHT-1): go to DIVIDE.
- DIVIDE: restoring division sum / (WIDTH*HEIGHT), exactly SUM_W cycles, one quotient bit per cycle; in_ready=0, busy=1; output register still drains normally. Quotient saturates to 0xFF (cannot occur at legal sums). On completion: frame_mean <= quotient, mean_valid <= 1, sum <= 0, return to STREAM.
- cfg_mode change takes effect only at next frame start.

## Timing
- Latency: pixel accepted in cycle N appears on out_pixel with out_valid in cycle N+1.
- Output register holds out_pixel/out_sof/out_eof stable while out_valid && !out_ready.
- Full throughput (1 pixel/cycle) within a frame when out_ready=1; SUM_W-cycle bubble on in_ready after each frame.
- Simultaneous output handoff and new input accept in same cycle allowed (no bubble).
- Reset values: in_ready=0 during reset, 1 the first cycle after (state STREAM, output empty); out_valid=0, out_pixel=0, out_sof=0, out_eof=0, frame_mean=0, busy=0; mean_valid=0, sum=0, counters=0.
- Reset mid-frame or mid-DIVIDE: all state discarded, next accepted pixel is (0,0) with out_sof; adaptive mode uses cfg_threshold until a full frame completes.
- in_valid with in_ready=0: no state change; upstream must hold data.

## Structure
- Shared package: frame geometry constants (WIDTH, HEIGHT, pixel count), BIN_ONE=8'hFF, BIN_ZERO=8'h00, FSM state enum — shared with the binary-to-RGB stage.
- One sub-module natural: seq_divider (start/done restoring divider, parameterized dividend/divisor widths), reused for other frame statistics.

## Test plan
- Static, cfg_threshold=0x80, 100 pixels all 0x80, out_ready=1 -> 100 outputs 0xFF, out_sof on 1st, out_eof on 100th, 1-cycle latency.
- Adaptive, frame 1 pixels 0..99 -> frame 1 uses cfg_threshold; busy high 15 cycles; frame_mean=49 (4950/100); frame 2 input 49 -> 0xFF, 48 -> 0x00.
- Backpressure: out_ready low 5 cycles mid-frame -> out_valid and out_pixel held, in_ready low, no pixel lost or duplicated over 100 transfers.
- Sparse in_valid (1 of 3 cycles) -> counters advance only on transfers; out_eof exactly on 100th output.
- Assert rst_n low at pixel 37 of adaptive frame 2 -> outputs return to reset values; next frame uses cfg_threshold, out_sof on first pixel.
- cfg_threshold changed 0x10->0xF0 mid-frame -> current frame keeps 0x10; next frame uses 0xF0.
